// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the execute-stage multiply/divide sequencer:
// operation encoding, word/counter types, FSM states and a W-op sign-extension helper.
package muldiv_sequencer_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 7;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [CNT_W-1:0] count_t;

    // Operation class handed over by decode; encoding 3 is reserved and runs as MUL.
    typedef enum logic [1:0] {
        MD_MUL = 2'd0,
        MD_DIV = 2'd1,
        MD_REM = 2'd2
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } md_state_t;

    localparam count_t CNT_FULL = count_t'(XLEN);
    localparam count_t CNT_CUT  = count_t'(32);

    // W-op results are the low word sign-extended to XLEN.
    function automatic word_t sextWord(input word_t v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

endpackage

// File: rtl/muldiv_sequencer_iter.sv
// Single radix-2 step of the multiply/divide datapath (purely combinational).
//  MUL: acc += sh[0] ? opnd : 0, opnd <<= 1, sh >>= 1 (shift-add).
//  DIV: {acc, sh} shifts left one bit; if the partial remainder covers the
//       divisor (opnd) it is reduced and a quotient 1 enters sh[0] (restoring).
module muldiv_sequencer_iter
    import muldiv_sequencer_pkg::*;
(
    input  logic            isDiv,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] sh,
    output logic [XLEN-1:0] accNext,
    output logic [XLEN-1:0] opndNext,
    output logic [XLEN-1:0] shNext
);

    logic [XLEN:0]   remShift;
    logic [XLEN-1:0] remSub;
    logic            remGe;

    // One iteration; the XLEN+1-bit compare covers partial remainders that spill past XLEN.
    always_comb begin
        remShift = {acc, sh[XLEN-1]};
        remGe    = (remShift >= {1'b0, opnd});
        // When remGe holds the true difference fits in XLEN bits, so modular subtract is exact.
        remSub   = remShift[XLEN-1:0] - opnd;
        if (isDiv) begin
            accNext  = remGe ? remSub : remShift[XLEN-1:0];
            opndNext = opnd;
            shNext   = {sh[XLEN-2:0], remGe};
        end else begin
            accNext  = acc + (sh[0] ? opnd : '0);
            opndNext = {opnd[XLEN-2:0], 1'b0};
            shNext   = {1'b0, sh[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV/REM engine for the execute stage: latches operands on start,
// runs one radix-2 step per cycle, stalls the pipeline via e_wait and pulses done_o
// with a held 64-bit result. Supports 32-bit W variants via cut_i.
// Build option: define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed overflow
// and |a|<|b| divides go straight from IDLE to DONE.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic            sign_i,
    input  logic            cut_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            e_wait,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    md_state_t  stateQ, stateD;
    count_t     countQ, countD;

    // Iteration registers: accQ = product / partial remainder,
    // opndQ = multiplicand / divisor, shQ = multiplier / dividend-then-quotient.
    word_t      accQ, opndQ, shQ;
    word_t      accNext, opndNext, shNext;

    logic       isDivQ, isRemQ, cutQ, negQuoQ, negRemQ, specialQ;
    word_t      specialValQ;
    word_t      resultQ;

    // Operand conditioning for the request presented in IDLE.
    muldiv_op_t opIn;
    logic       isDivIn, isRemIn;
    word_t      aExt, bExt, aMag, bMag, minWord;
    logic       aNeg, bNeg, divZero, divOvf, specialIn;
    word_t      specialValIn;
    logic       accept, eWaitC, lastStep;
    word_t      rawRes, finalRes;
`ifdef MULDIV_EARLY_OUT_EN
    logic       earlyIn;
    word_t      earlyRes;
`endif

    assign accept = (stateQ == StIdle) && start_i && !flush_i;

    // Decode the request, extend W operands and precompute the divide special cases.
    always_comb begin
        opIn    = (op_i == 2'd3) ? MD_MUL : muldiv_op_t'(op_i);
        isDivIn = (opIn == MD_DIV) || (opIn == MD_REM);
        isRemIn = (opIn == MD_REM);

        aExt = a_i;
        bExt = b_i;
        if (cut_i) begin
            aExt = {{(XLEN-32){sign_i & a_i[31]}}, a_i[31:0]};
            bExt = {{(XLEN-32){sign_i & b_i[31]}}, b_i[31:0]};
        end

        aNeg = isDivIn & sign_i & aExt[XLEN-1];
        bNeg = isDivIn & sign_i & bExt[XLEN-1];
        aMag = aNeg ? -aExt : aExt;
        bMag = bNeg ? -bExt : bExt;

        minWord = cut_i ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
        divZero = (bExt == '0);
        divOvf  = sign_i & (aExt == minWord) & (bExt == '1);

        specialIn = isDivIn & (divZero | divOvf);
        // The last branch is the |a|<|b| case, only reached by the early-out path.
        if (divZero) begin
            specialValIn = isRemIn ? aExt : '1;
        end else if (divOvf) begin
            specialValIn = isRemIn ? '0 : aExt;
        end else begin
            specialValIn = isRemIn ? aExt : '0;
        end
`ifdef MULDIV_EARLY_OUT_EN
        earlyIn  = isDivIn & (divZero | divOvf | (aMag < bMag));
        earlyRes = cut_i ? sextWord(specialValIn) : specialValIn;
`endif
    end

    muldiv_sequencer_iter uIter (
        .isDiv    (isDivQ),
        .acc      (accQ),
        .opnd     (opndQ),
        .sh       (shQ),
        .accNext  (accNext),
        .opndNext (opndNext),
        .shNext   (shNext)
    );

    // Sign fix-up and W extension applied to the outcome of the final iteration.
    always_comb begin
        rawRes = accNext;
        if (isDivQ) begin
            if (isRemQ) begin
                rawRes = negRemQ ? -accNext : accNext;
            end else begin
                rawRes = negQuoQ ? -shNext : shNext;
            end
        end
        if (specialQ) begin
            rawRes = specialValQ;
        end
        finalRes = cutQ ? sextWord(rawRes) : rawRes;
    end

    // FSM next state, iteration counter and stall request.
    always_comb begin
        stateD   = stateQ;
        countD   = countQ;
        eWaitC   = 1'b0;
        lastStep = 1'b0;
        unique case (stateQ)
            StIdle: begin
                eWaitC = start_i;
                if (accept) begin
                    countD = cut_i ? CNT_CUT : CNT_FULL;
                    stateD = StBusy;
`ifdef MULDIV_EARLY_OUT_EN
                    if (earlyIn) begin
                        countD = '0;
                        stateD = StDone;
                    end
`endif
                end
            end
            StBusy: begin
                eWaitC = 1'b1;
                countD = countQ - count_t'(1);
                if (countQ == count_t'(1)) begin
                    stateD   = StDone;
                    lastStep = 1'b1;
                end
            end
            StDone: begin
                // A start still asserted here belongs to the retiring instruction.
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
        if (flush_i) begin
            stateD   = StIdle;
            lastStep = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= StIdle;
            countQ <= '0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
        end
    end

    // Operand latch on accept, then one datapath step per BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accQ        <= '0;
            opndQ       <= '0;
            shQ         <= '0;
            isDivQ      <= 1'b0;
            isRemQ      <= 1'b0;
            cutQ        <= 1'b0;
            negQuoQ     <= 1'b0;
            negRemQ     <= 1'b0;
            specialQ    <= 1'b0;
            specialValQ <= '0;
        end else if (accept) begin
            accQ        <= '0;
            opndQ       <= isDivIn ? bMag : aExt;
            // A W dividend is pre-aligned to the top so 32 steps consume exactly its bits.
            shQ         <= isDivIn ? (cut_i ? {aMag[31:0], 32'b0} : aMag) : bExt;
            isDivQ      <= isDivIn;
            isRemQ      <= isRemIn;
            cutQ        <= cut_i;
            negQuoQ     <= aNeg ^ bNeg;
            negRemQ     <= aNeg;
            specialQ    <= specialIn;
            specialValQ <= specialValIn;
        end else if (stateQ == StBusy) begin
            accQ  <= accNext;
            opndQ <= opndNext;
            shQ   <= shNext;
        end
    end

    // Result is captured on the way into DONE so it is valid alongside the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resultQ <= '0;
        end else if (lastStep) begin
            resultQ <= finalRes;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (accept && earlyIn) begin
            resultQ <= earlyRes;
`endif
        end
    end

    assign e_wait   = eWaitC & ~reset;
    assign done_o   = (stateQ == StDone);
    assign result_o = resultQ;

endmodule
